mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the pipelined core's fetch
//  port (PCF/InstrF) and its data port (ALUResultM/WriteDataM/ReadDataM).
//  Sequences one memory transaction at a time and raises a pipeline stall while either
//  requester waits.
//  Data requests win by default. A streak counter guarantees that fetch cannot starve.
//  A watchdog terminates transactions that are never acknowledged.
// PARAMETERS
//  AW            32  address width
//  DW            32  data width
//  DM_STREAK_MAX 4   consecutive data grants while fetch pending before fetch is forced (>=1)
//  TIMEOUT_CYC   64  busy cycles without mem_ack before abort; 0 = watchdog disabled
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  if_req     in   1   fetch request; held with if_addr stable until if_ready
//  if_addr    in   AW  fetch address (PCF)
//  if_rdata   out  DW  fetched instruction; valid only while if_ready=1
//  if_ready   out  1   fetch complete, single-cycle pulse
//  dm_req     in   1   data request; held with dm_* stable until dm_ready
//  dm_we      in   1   1 = store, 0 = load
//  dm_addr    in   AW  data address (ALUResultM)
//  dm_wdata   in   DW  store data (WriteDataM)
//  dm_rdata   out  DW  load data; valid only while dm_ready=1
//  dm_ready   out  1   data access complete, single-cycle pulse
//  mem_req    out  1   memory request; held high until mem_ack or abort
//  mem_we     out  1   memory write enable; qualified by mem_req
//  mem_addr   out  AW  memory address, registered
//  mem_wdata  out  DW  memory write data, registered
//  mem_rdata  in   DW  memory read data; valid in the mem_ack cycle
//  mem_ack    in   1   memory completes the current request this cycle
//  stall      out  1   freeze pipeline: (if_req & ~if_ready) | (dm_req & ~dm_ready)
//  err        out  1   sticky watchdog-abort flag
// BEHAVIOUR
//  Reset (async, reset=0):
//   - state=IDLE; mem_req, mem_we, err, if_ready and dm_ready all 0.
//   - mem_addr, mem_wdata, streak counter and watchdog counter all 0.
//   - Reset asserted mid-transaction drops mem_req immediately; no ready pulse is issued.
//  FSM states: IDLE, BUSY_IF, BUSY_DM.
//  Grant decision in IDLE, on a clock edge:
//   - If dm_req and not (if_req and streak==DM_STREAK_MAX): go to BUSY_DM.
//     Latch dm_addr, dm_wdata, dm_we.
//     Streak increments (saturating) if if_req=1; otherwise streak clears.
//   - Else if if_req: go to BUSY_IF. Latch if_addr, set mem_we=0, clear streak.
//   - Else stay in IDLE.
//   - mem_req=1 from the cycle after the grant edge.
//  BUSY_x:
//   - mem_req, mem_addr, mem_wdata and mem_we are held constant.
//   - x_ready = mem_ack, combinational. x_rdata = mem_rdata (passthrough).
//   - On the ack edge: return to IDLE, clear mem_req, clear the watchdog.
//  Latency: request sampled at edge N, mem_req high at N+1, earliest ready is in cycle N+1
//   (same-cycle ack). The next grant is at the edge after ack, so the minimum is 2 cycles
//   per access.
//  Requester drops its request before ready: the transaction still completes, the ready
//   pulse still fires, and no new grant is made for the withdrawn request.
//  Watchdog (TIMEOUT_CYC>0):
//   - Counts cycles in BUSY_x. When the count reaches TIMEOUT_CYC with no ack, x_ready
//     pulses with x_rdata=0.
//   - The FSM returns to IDLE and err is set (cleared only by reset).
//   - An ack in the same cycle as the timeout wins: normal completion, err unchanged.
//  if_ready and dm_ready are never high in the same cycle.
//  mem_req never drops without an ack, a timeout or reset.
// TESTING
//  T1 if_req=1, if_addr=0x10, mem_ack 2 cycles after mem_req -> mem_addr=0x10, mem_we=0.
//     mem_req high 3 cycles; if_ready pulses once in the ack cycle; if_rdata=mem_rdata.
//     stall=1 until then.
//  T2 if_req and dm_req (load, 0x200) both rise in one cycle -> data served first
//     (mem_addr=0x200), then fetch; stall stays 1 until if_ready.
//  T3 DM_STREAK_MAX=2, if_req held, dm_req held with new addr per ready -> grant order
//     DM, DM, IF, DM.
//  T4 Store dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1 with those values
//     latched; dm_ready pulses on ack.
//  T5 TIMEOUT_CYC=8, no mem_ack -> mem_req drops after 8 busy cycles; dm_ready=1 with
//     dm_rdata=0; err=1 and stays 1.
//  T6 reset=0 in the 2nd busy cycle -> mem_req=0 and state=IDLE at once, no ready pulse.
//     After release the pending request is re-granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins by default; a streak limit and a watchdog bound fetch starvation and hangs.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int DM_STREAK_MAX = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  localparam int SW = (DM_STREAK_MAX > 1) ? $clog2(DM_STREAK_MAX + 1) : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [SW-1:0] STREAK_TOP = SW'(DM_STREAK_MAX);
  localparam logic [WW-1:0] WDOG_LAST  =
    WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic          busy;
  logic          timeout;
  logic          done;
  logic          forceIf;
  logic          grantDm;
  logic          grantIf;

  assign busy    = (state != IDLE);
  assign done    = busy & (mem_ack | timeout);
  assign forceIf = if_req & (streak == STREAK_TOP);
  assign grantDm = dm_req & ~forceIf;
  assign grantIf = if_req & ~grantDm;

  assign mem_req  = busy;
  assign if_ready = (state == BUSY_IF) & done;
  assign dm_ready = (state == BUSY_DM) & done;

  // A watchdog abort returns zero rather than whatever is on the bus.
  assign if_rdata =
    ((state == BUSY_IF) && mem_ack) ? mem_rdata : '0;
  assign dm_rdata =
    ((state == BUSY_DM) && mem_ack) ? mem_rdata : '0;

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            grantDm: state <= BUSY_DM;
            grantIf: state <= BUSY_IF;
            default: state <= IDLE;
          endcase
        end
        BUSY_IF, BUSY_DM: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (state == IDLE) begin
      unique case (1'b1)
        grantDm: begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_we    <= dm_we;
        end
        grantIf: begin
          mem_addr <= if_addr;
          mem_we   <= 1'b0;
        end
        default: ;
      endcase
    end else if (done) begin
      mem_we <= 1'b0;
    end
  end

  // Streak only grows while fetch is actually waiting behind data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (state == IDLE) begin
      unique case (1'b1)
        grantDm: begin
          if (!if_req)
            streak <= '0;
          else if (streak != STREAK_TOP)
            streak <= streak + 1'b1;
        end
        grantIf: streak <= '0;
        default: ;
      endcase
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : gWdog
      logic [WW-1:0] wdog;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          wdog <= '0;
        else if (busy && !done)
          wdog <= wdog + 1'b1;
        else
          wdog <= '0;
      end

      assign timeout = busy & (wdog == WDOG_LAST);
    end else begin : gNoWdog
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err <= 1'b0;
    else if (timeout && !mem_ack)
      err <= 1'b1;
  end

  readyExclusive: assert property (
    @(posedge clk) disable iff (!reset)
    !(if_ready && dm_ready));

  reqHeld: assert property (
    @(posedge clk) disable iff (!reset)
    (mem_req && !done) |=> (mem_req && $stable(mem_addr)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against
// a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 2;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW),
    .DM_STREAK_MAX(SMAX),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory, what was latched,
  // how many busy cycles have elapsed, and the fairness streak.
  int          owner;   // 0 none, 1 fetch, 2 data
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic        mWe;
  int          age;
  int          streak;
  logic        mErr;

  logic        lastIf;
  logic        lastDm;
  logic        prevMemReq;
  int          memReqCnt;
  logic [31:0] grantAddrs[$];
  logic        grantWe[$];
  logic [31:0] grantWdata[$];

  int          ackAt;
  bit          randomAck;

  task automatic modelReset();
    owner = 0; age = 0; streak = 0;
    mErr = 1'b0; mAddr = '0; mWdata = '0; mWe = 1'b0;
    lastIf = 1'b0; lastDm = 1'b0; prevMemReq = 1'b0;
  endtask

  task automatic checkNow();
    bit busy, to, done, eIf, eDm;
    busy = (owner != 0);
    to   = busy && (age + 1 == TO);
    done = busy && (mem_ack || to);
    eIf  = (owner == 1) && done;
    eDm  = (owner == 2) && done;
    chk("if_ready", if_ready, eIf);
    chk("dm_ready", dm_ready, eDm);
    if (eIf) chk("if_rdata", if_rdata, mem_ack ? mem_rdata : 32'h0);
    if (eDm) chk("dm_rdata", dm_rdata, mem_ack ? mem_rdata : 32'h0);
    chk("stall", stall, (if_req && !eIf) || (dm_req && !eDm));
    chk("mem_req", mem_req, busy);
    if (busy) begin
      chk("mem_addr", mem_addr, mAddr);
      chk("mem_we", mem_we, mWe);
      if (owner == 2 && mWe) chk("mem_wdata", mem_wdata, mWdata);
    end
    chk("err", err, mErr);
    if (mem_req) memReqCnt++;
    if (mem_req && !prevMemReq) begin
      grantAddrs.push_back(mem_addr);
      grantWe.push_back(mem_we);
      grantWdata.push_back(mem_wdata);
    end
    prevMemReq = mem_req;
    lastIf = eIf;
    lastDm = eDm;
  endtask

  task automatic modelEdge();
    if (owner != 0) begin
      if (mem_ack || (age + 1 == TO)) begin
        if (!mem_ack) mErr = 1'b1;
        owner = 0;
        age = 0;
      end else begin
        age++;
      end
    end else if (dm_req && !(if_req && streak == SMAX)) begin
      owner = 2; age = 0;
      mAddr = dm_addr; mWdata = dm_wdata; mWe = dm_we;
      streak = if_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
    end else if (if_req) begin
      owner = 1; age = 0;
      mAddr = if_addr; mWe = 1'b0;
      streak = 0;
    end
  endtask

  task automatic setAck();
    if (randomAck && owner != 0 && age == 0)
      ackAt = $urandom_range(0, 5);
    mem_ack   = (owner != 0) && (age == ackAt);
    mem_rdata = $urandom;
  endtask

  task automatic cycle();
    #1 checkNow();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic runUntil(input int which, input int maxCyc,
                          input string tag);
    int n;
    n = 0;
    forever begin
      setAck();
      cycle();
      n++;
      if ((which == 1 && lastIf) || (which == 2 && lastDm)) break;
      if (n >= maxCyc) begin
        total++; bad++;
        $display("FAIL %s no ready within %0d cycles", tag, maxCyc);
        break;
      end
    end
  endtask

  task automatic drain();
    if_req = 1'b0;
    dm_req = 1'b0;
    for (int i = 0; i < 20 && owner != 0; i++) begin
      setAck();
      cycle();
    end
    setAck();
    cycle();
  endtask

  task automatic clearLog();
    grantAddrs.delete();
    grantWe.delete();
    grantWdata.delete();
    memReqCnt = 0;
  endtask

  task automatic randDrive();
    if (!if_req) begin
      if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFC;
      end
    end else if (lastIf) begin
      if_req = 1'($urandom_range(0, 1));
      if_addr = $urandom & 32'hFFFC;
    end else if ($urandom_range(0, 60) == 0) begin
      if_req = 1'b0;
    end
    if (!dm_req) begin
      if ($urandom_range(0, 2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom & 32'hFFFC; dm_wdata = $urandom;
      end
    end else if (lastDm) begin
      dm_req = 1'($urandom_range(0, 1));
      dm_we = 1'($urandom_range(0, 1));
      dm_addr = $urandom & 32'hFFFC; dm_wdata = $urandom;
    end else if ($urandom_range(0, 60) == 0) begin
      dm_req = 1'b0;
    end
  endtask

  initial begin
    modelReset();
    clearLog();
    randomAck = 1'b0;
    ackAt = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // T1: single fetch, ack in the third busy cycle
    clearLog();
    if_req = 1'b1; if_addr = 32'h10; ackAt = 2;
    runUntil(1, 20, "t1");
    if_req = 1'b0;
    chk("t1_req_cycles", memReqCnt, 3);
    chk("t1_grants", grantAddrs.size(), 1);
    if (grantAddrs.size() == 1) chk("t1_addr", grantAddrs[0], 32'h10);
    drain();

    // T4: store latches address, data and write enable
    clearLog();
    dm_req = 1'b1; dm_we = 1'b1;
    dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; ackAt = 1;
    runUntil(2, 20, "t4");
    dm_req = 1'b0; dm_we = 1'b0;
    chk("t4_grants", grantAddrs.size(), 1);
    if (grantAddrs.size() == 1) begin
      chk("t4_addr", grantAddrs[0], 32'h40);
      chk("t4_we", grantWe[0], 1'b1);
      chk("t4_wdata", grantWdata[0], 32'hDEADBEEF);
    end
    drain();

    // T2: simultaneous requests, data first
    clearLog();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_addr = 32'h200; ackAt = 1;
    runUntil(2, 20, "t2_dm");
    dm_req = 1'b0;
    runUntil(1, 20, "t2_if");
    if_req = 1'b0;
    chk("t2_grants", grantAddrs.size(), 2);
    if (grantAddrs.size() == 2) begin
      chk("t2_first", grantAddrs[0], 32'h200);
      chk("t2_second", grantAddrs[1], 32'h20);
    end
    drain();

    // T3: fetch forced in after SMAX data grants
    clearLog();
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_addr = 32'h400; ackAt = 0;
    for (int i = 0; i < 60 && grantAddrs.size() < 4; i++) begin
      setAck();
      cycle();
      if (lastDm) dm_addr = dm_addr + 4;
      if (lastIf) if_addr = 32'h300;
    end
    drain();
    repeat (3) begin setAck(); cycle(); end
    chk("t3_grants", grantAddrs.size(), 4);
    if (grantAddrs.size() == 4) begin
      chk("t3_g0", grantAddrs[0], 32'h400);
      chk("t3_g1", grantAddrs[1], 32'h404);
      chk("t3_g2", grantAddrs[2], 32'h300);
      chk("t3_g3", grantAddrs[3], 32'h408);
    end

    // Randomized traffic, acks always before the watchdog
    randomAck = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      randDrive();
      setAck();
      cycle();
    end
    randomAck = 1'b0;
    ackAt = 1;
    drain();
    chk("rand_err", err, 1'b0);

    // Ack in the very cycle the watchdog expires
    clearLog();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; ackAt = TO - 1;
    runUntil(2, 20, "edge");
    dm_req = 1'b0;
    chk("edge_req_cycles", memReqCnt, TO);
    chk("edge_err", err, 1'b0);
    drain();

    // T5: no ack at all
    clearLog();
    dm_req = 1'b1; dm_addr = 32'h90; ackAt = 1000;
    runUntil(2, 20, "t5");
    dm_req = 1'b0;
    chk("t5_req_cycles", memReqCnt, TO);
    drain();
    repeat (5) begin setAck(); cycle(); end
    chk("t5_err_sticky", err, 1'b1);

    // T6: reset during the second busy cycle
    clearLog();
    if_req = 1'b1; if_addr = 32'h60; ackAt = 1000;
    for (int i = 0; i < 10 && !(owner != 0 && age == 1); i++) begin
      setAck();
      cycle();
    end
    chk("t6_reached", age, 1);
    mem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_if_ready", if_ready, 1'b0);
    chk("t6_dm_ready", dm_ready, 1'b0);
    chk("t6_err", err, 1'b0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearLog();
    ackAt = 1;
    runUntil(1, 20, "t6_regrant");
    if_req = 1'b0;
    chk("t6_grants", grantAddrs.size(), 1);
    if (grantAddrs.size() == 1) chk("t6_addr", grantAddrs[0], 32'h60);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
